// File: rtl/half_base2_log.sv
// half_base2_log
//   Iterative base-2 logarithm for IEEE-754 half precision. The unit produces
//   one fraction bit per cycle by repeated mantissa squaring, then rounds the
//   fixed-point result back to half precision (round to nearest, ties to even).
//   Latency from the accept edge to the result is ITERS + 2 cycles. A new
//   operand can be accepted every ITERS + 3 cycles.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears all state
//   in_valid   operand present on a
//   in_ready   high while idle; accept happens when in_valid && in_ready
//   a          operand, half in a[15:0]; a[31:16] is ignored
//   out_valid  one-cycle pulse: c holds a new result
//   c          result, half in c[15:0]; c[31:16] is always zero; held between results
module half_base2_log #(
    parameter int ITERS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic        out_valid,
    output logic [31:0] c
);

    localparam int CW = $clog2(ITERS + 1);
    localparam int RW = ITERS + 6;   // signed log: 6 integer bits, ITERS fraction bits
    localparam int AW = RW - 1;      // magnitude of the log

    typedef enum logic [2:0] {S_IDLE, S_NORM, S_ITER, S_PACK, S_OUT} state_t;

    state_t            state_q, state_d;
    logic [15:0]       op_q, op_d;
    logic [5:0]        e_q, e_d;          // two's-complement exponent
    logic [23:0]       m_q, m_d;          // mantissa, Q1.23
    logic [ITERS-1:0]  frac_q, frac_d;    // log fraction bits, MSB first
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              special_q, special_d;
    logic [15:0]       spec_res_q, spec_res_d;
    logic [15:0]       res_q, res_d;
    logic [31:0]       c_q, c_d;
    logic              out_valid_q, out_valid_d;

    // Operand classification and normalization (used in NORM)
    logic              n_special;
    logic [15:0]       n_spec_res;
    logic [5:0]        e_norm;
    logic [23:0]       m_norm;
    int                lead_p;

    always_comb begin
        n_special  = 1'b1;
        n_spec_res = 16'h0000;
        lead_p     = 0;
        for (int i = 0; i < 10; i++) begin
            if (op_q[i]) lead_p = i;
        end
        if (op_q[14:0] == 15'd0) begin
            n_spec_res = 16'hFC00;                       // log2(+-0) = -inf
        end else if (op_q[14:10] == 5'h1F && op_q[9:0] != 10'd0) begin
            n_spec_res = 16'h7E00;                       // NaN in, quiet NaN out
        end else if (op_q[15]) begin
            n_spec_res = 16'h7E00;                       // negative operand, incl. -inf
        end else if (op_q[14:10] == 5'h1F) begin
            n_spec_res = 16'h7C00;                       // log2(+inf) = +inf
        end else begin
            n_special  = 1'b0;
        end
        if (op_q[14:10] == 5'd0) begin
            // Subnormal: move the leading one of the fraction up to the integer bit.
            m_norm = {14'd0, op_q[9:0]} << (23 - lead_p);
            e_norm = 6'(lead_p - 24);
        end else begin
            m_norm = {1'b1, op_q[9:0], 13'd0};
            e_norm = {1'b0, op_q[14:10]} - 6'd15;
        end
    end

    // One squaring step; the NORM cycle squares the freshly normalized mantissa
    // so that all ITERS bits are produced by the time the FSM reaches PACK.
    logic [23:0] m_src;
    logic [47:0] sq;
    logic [23:0] m_next;

    always_comb begin
        m_src  = (state_q == S_NORM) ? m_norm : m_q;
        sq     = {24'd0, m_src} * {24'd0, m_src};
        m_next = sq[47] ? sq[47:24] : sq[46:23];   // truncating renormalization
    end

    // Fixed-point log back to half precision
    logic [RW-1:0] r_val;
    logic [RW-1:0] r_abs;
    logic [AW-1:0] mag;
    logic [AW-1:0] norm_v;
    logic [AW-1:0] sub_v;
    logic [10:0]   sig;
    logic          guard;
    logic          sticky;
    logic          round_up;
    logic [15:0]   pack_res;
    int            lead_l;
    int            biased;

    always_comb begin
        r_val  = {e_q, frac_q};
        r_abs  = r_val[RW-1] ? (~r_val + RW'(1)) : r_val;
        mag    = r_abs[AW-1:0];
        lead_l = 0;
        for (int i = 0; i < AW; i++) begin
            if (mag[i]) lead_l = i;
        end
        biased   = lead_l - ITERS + 15;
        norm_v   = mag << (AW - 1 - lead_l);
        sig      = norm_v[AW-1 -: 11];
        guard    = norm_v[AW-12];
        sticky   = |norm_v[AW-13:0];
        round_up = guard & (sticky | sig[0]);
        // Below 2^-14 the value is a small multiple of 2^-ITERS and fits a half subnormal exactly.
        sub_v    = mag << (24 - ITERS);
        if (r_val == '0) begin
            pack_res = 16'h0000;
        end else if (biased >= 1) begin
            // A carry out of the significand rolls into the exponent field.
            pack_res = {r_val[RW-1], {5'(biased), sig[9:0]} + 15'(round_up)};
        end else begin
            pack_res = {r_val[RW-1], 5'd0, sub_v[9:0]};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{a[31:16], sq[22:0], r_abs[RW-1], sig[10], sub_v[AW-1:10]};

    // NOTE: every _d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        e_d         = e_q;
        m_d         = m_q;
        frac_d      = frac_q;
        cnt_d       = cnt_q;
        special_d   = special_q;
        spec_res_d  = spec_res_q;
        res_d       = res_q;
        c_d         = c_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = a[15:0];
                    frac_d  = '0;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                special_d  = n_special;
                spec_res_d = n_spec_res;
                e_d        = e_norm;
                m_d        = m_next;
                frac_d     = {frac_q[ITERS-2:0], sq[47]};
                cnt_d      = CW'(1);
                state_d    = S_ITER;
            end
            S_ITER: begin
                m_d    = m_next;
                frac_d = {frac_q[ITERS-2:0], sq[47]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(ITERS - 1)) state_d = S_PACK;
            end
            S_PACK: begin
                res_d   = special_q ? spec_res_q : pack_res;
                state_d = S_OUT;
            end
            S_OUT: begin
                c_d         = {16'd0, res_q};
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            e_q         <= '0;
            m_q         <= '0;
            frac_q      <= '0;
            cnt_q       <= '0;
            special_q   <= 1'b0;
            spec_res_q  <= '0;
            res_q       <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            e_q         <= e_d;
            m_q         <= m_d;
            frac_q      <= frac_d;
            cnt_q       <= cnt_d;
            special_q   <= special_d;
            spec_res_q  <= spec_res_d;
            res_q       <= res_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign c         = c_q;

endmodule

// File: tb/tb_half_base2_log.sv
// tb_half_base2_log
//   Self-checking bench for half_base2_log: directed vector table, a sampled
//   sweep of positive finite operands against an independent model, a
//   back-to-back throughput sequence, and reset corner cases.
module tb_half_base2_log;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        out_valid;
    logic [31:0] c;

    int n_checks = 0;
    int n_pass   = 0;

    half_base2_log #(.ITERS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .c         (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    // Independent reference: integer squaring loop, remainder-based RNE.
    function automatic logic [15:0] model_log2(input logic [15:0] h);
        int     ex, fr, e, p, bits, r, mag, ld, sig, sh, rem, half;
        longint m, sq;
        logic   s;
        ex = int'(h[14:10]);
        fr = int'(h[9:0]);
        if (ex == 0 && fr == 0) return 16'hFC00;
        if (ex == 31 && fr != 0) return 16'h7E00;
        if (h[15]) return 16'h7E00;
        if (ex == 31) return 16'h7C00;
        if (ex == 0) begin
            p = 0;
            for (int i = 0; i < 10; i++) if (((fr >> i) & 1) != 0) p = i;
            m = longint'(fr) << (23 - p);
            e = p - 24;
        end else begin
            m = longint'(1024 + fr) << 13;
            e = ex - 15;
        end
        bits = 0;
        for (int i = 0; i < 16; i++) begin
            sq   = m * m;
            bits = bits * 2;
            if (sq >= (longint'(1) << 47)) begin
                bits = bits + 1;
                m    = sq >>> 24;
            end else begin
                m    = sq >>> 23;
            end
        end
        r = e * 65536 + bits;
        if (r == 0) return 16'h0000;
        s   = (r < 0);
        mag = s ? -r : r;
        ld  = 0;
        for (int i = 0; i < 31; i++) if (((mag >> i) & 1) != 0) ld = i;
        if (ld < 2) return {s, 5'd0, 10'(mag << 8)};
        if (ld <= 10) begin
            sig = mag << (10 - ld);
        end else begin
            sh   = ld - 10;
            sig  = mag >> sh;
            rem  = mag - (sig << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (sig % 2) == 1)) sig = sig + 1;
            if (sig == 2048) begin
                sig = 1024;
                ld  = ld + 1;
            end
        end
        return {s, 5'(ld - 1), 10'(sig)};
    endfunction

    // Present one operand from idle and wait (bounded) for its result.
    task automatic run_op(input logic [31:0] op, output logic rdy, output logic [31:0] res,
                          output int lat, output int width);
        @(negedge clk);
        rdy      = in_ready;
        in_valid = 1'b1;
        a        = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = -1;
        res      = 32'hxxxx_xxxx;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        res = c;
        @(posedge clk);
        #1;
        width = out_valid ? 2 : 1;
    endtask

    typedef struct {
        logic [31:0] op;
        logic [31:0] exp_c;
    } vec_t;

    vec_t        vecs[17];
    logic [15:0] ops[61];
    logic [15:0] extra[8];
    int          pulse_t[$];
    logic [31:0] pulse_c[$];

    initial begin
        logic        rdy;
        logic [31:0] res;
        int          lat, width, seen;

        vecs[0]  = '{32'h0000_4000, 32'h0000_3C00};  // 2.0 -> 1
        vecs[1]  = '{32'h0000_4800, 32'h0000_4200};  // 8.0 -> 3
        vecs[2]  = '{32'h0000_3800, 32'h0000_BC00};  // 0.5 -> -1
        vecs[3]  = '{32'h0000_3C00, 32'h0000_0000};  // 1.0 -> 0
        vecs[4]  = '{32'h0000_0000, 32'h0000_FC00};  // +0 -> -inf
        vecs[5]  = '{32'h0000_8000, 32'h0000_FC00};  // -0 -> -inf
        vecs[6]  = '{32'h0000_BC00, 32'h0000_7E00};  // -1.0 -> NaN
        vecs[7]  = '{32'h0000_7C00, 32'h0000_7C00};  // +inf -> +inf
        vecs[8]  = '{32'h0000_FC00, 32'h0000_7E00};  // -inf -> NaN
        vecs[9]  = '{32'h0000_7E01, 32'h0000_7E00};  // NaN -> NaN
        vecs[10] = '{32'h0000_0001, 32'h0000_CE00};  // 2^-24 -> -24
        vecs[11] = '{32'h0000_0200, 32'h0000_CB80};  // 2^-15 -> -15
        vecs[12] = '{32'h0000_8001, 32'h0000_7E00};  // negative subnormal -> NaN
        vecs[13] = '{32'hDEAD_4000, 32'h0000_3C00};  // upper half ignored
        vecs[14] = '{32'h0000_4400, 32'h0000_4000};  // 4.0 -> 2
        vecs[15] = '{32'h0000_3400, 32'h0000_C000};  // 0.25 -> -2
        vecs[16] = '{32'h0000_0400, 32'h0000_CB00};  // 2^-14 -> -14

        reset    = 1'b1;
        in_valid = 1'b0;
        a        = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset c", c, 32'd0);

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].op, rdy, res, lat, width);
            check($sformatf("vec%0d ready", i), 32'(rdy), 32'd1);
            check($sformatf("vec%0d c", i), res, vecs[i].exp_c);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd18);
            check($sformatf("vec%0d pulse width", i), 32'(width), 32'd1);
        end

        // Result is held after the pulse
        repeat (5) @(posedge clk);
        #1;
        check("c held", c, 32'h0000_CB00);

        // Sampled sweep of positive finite operands plus boundary operands
        for (int v = 1; v <= 16'h7BFF; v += 13) begin
            run_op(32'(v), rdy, res, lat, width);
            check($sformatf("sweep %h", v[15:0]), res, {16'd0, model_log2(16'(v))});
        end
        extra = '{16'h03FF, 16'h0401, 16'h7BFF, 16'h3BFF, 16'h3C01, 16'h0003, 16'h3C02, 16'h4001};
        for (int i = 0; i < 8; i++) begin
            run_op({16'd0, extra[i]}, rdy, res, lat, width);
            check($sformatf("edge %h", extra[i]), res, {16'd0, model_log2(extra[i])});
        end

        // in_valid held high with a new operand every cycle
        for (int t = 0; t < 61; t++) ops[t] = 16'h1000 + 16'(t * 16'h0100);
        @(negedge clk);
        in_valid = 1'b1;
        a        = {16'd0, ops[0]};
        for (int t = 0; t < 60; t++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                pulse_t.push_back(t);
                pulse_c.push_back(c);
            end
            @(negedge clk);
            a = {16'd0, ops[t+1]};
        end
        in_valid = 1'b0;
        check("stream pulses", 32'(pulse_t.size()), 32'd3);
        for (int j = 0; j < 3; j++) begin
            if (j < pulse_t.size()) begin
                check($sformatf("stream%0d time", j), 32'(pulse_t[j]), 32'(18 + 19 * j));
                check($sformatf("stream%0d c", j), pulse_c[j], {16'd0, model_log2(ops[19 * j])});
            end
        end
        repeat (30) @(posedge clk);
        #1;
        check("stream drain c", c, {16'd0, model_log2(ops[57])});
        check("stream drain ready", 32'(in_ready), 32'd1);

        // Reset in the middle of the iterations
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h0000_4800;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort c", c, 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort no result", 32'(seen), 32'd0);
        run_op(32'h0000_4000, rdy, res, lat, width);
        check("after abort c", res, 32'h0000_3C00);
        check("after abort latency", 32'(lat), 32'd18);

        // reset and in_valid on the same edge: operand dropped
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        a        = 32'h0000_4800;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        check("reset+valid in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("reset+valid no result", 32'(seen), 32'd0);
        check("reset+valid c", c, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
